// File: rtl/core_v_mcu_pkg.sv
// core_v_mcu_pkg: shared register-bus types and arbiter configuration constants.
package core_v_mcu_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  localparam int NumRegArbReq        = 2;
  localparam int RegArbTimeoutCycles = 256;

  typedef enum logic [1:0] {ArbIdle, ArbBusy, ArbErr} arb_state_e;

  function automatic int rr_next(int idx, int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/reg_rr_pick.sv
// reg_rr_pick: combinational round-robin picker, first valid at or above ptr with wrap.
module reg_rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any_valid
);

  function automatic logic [W-1:0] slot(logic [W-1:0] p, int i);
    return W'((int'(p) + i) % N);
  endfunction

  // Walk downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (valid[slot(ptr, i)]) idx = slot(ptr, i);
  end

  assign any_valid = |valid;

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin register-bus arbiter with locked grant and timeout abort.
module reg_bus_arbiter
  import core_v_mcu_pkg::*;
#(
  parameter int NumReq        = NumRegArbReq,
  parameter int TimeoutCycles = RegArbTimeoutCycles,
  parameter int CntWidth      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1,
  localparam int IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  reg_req_t        in_req_i [NumReq],
  output reg_rsp_t        in_rsp_o [NumReq],
  output reg_req_t        out_req_o,
  input  reg_rsp_t        out_rsp_i,
  output logic            busy_o,
  output logic            timeout_o,
  output logic [IdxW-1:0] timeout_idx_o
);

  if (NumReq < 2 || NumReq > 8) begin : g_bad_num_req
    $error("reg_bus_arbiter: NumReq must be within 2..8");
  end

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       gnt_q, gnt_d, ptr_q, ptr_d, pick, tidx_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [NumReq-1:0]     valid_vec;
  logic                  any_valid;

  for (genvar i = 0; i < NumReq; i++) begin : g_valid
    assign valid_vec[i] = in_req_i[i].valid;
  end

  reg_rr_pick #(.N(NumReq), .W(IdxW)) u_pick (
    .valid     (valid_vec),
    .ptr       (ptr_q),
    .idx       (pick),
    .any_valid (any_valid)
  );

  function automatic logic [IdxW-1:0] nxt(logic [IdxW-1:0] idx);
    return IdxW'(rr_next(int'(idx), NumReq));
  endfunction

  // The IDLE pick is gated by reset so the slave sees valid drop while rst_ni is low.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    out_req_o = '0;
    for (int i = 0; i < NumReq; i++) in_rsp_o[i] = '0;
    case (state_q)
      ArbIdle: if (any_valid && rst_ni) begin
        out_req_o      = in_req_i[pick];
        in_rsp_o[pick] = out_rsp_i;
        if (out_rsp_i.ready) ptr_d = nxt(pick);
        else begin
          state_d = ArbBusy;
          gnt_d   = pick;
          cnt_d   = '0;
        end
      end
      ArbBusy: begin
        out_req_o       = in_req_i[gnt_q];
        in_rsp_o[gnt_q] = out_rsp_i;
        if (out_rsp_i.ready) begin
          state_d = ArbIdle;
          ptr_d   = nxt(gnt_q);
        end else if (TimeoutCycles != 0 && cnt_q == CntLast) state_d = ArbErr;
        else cnt_d = cnt_q + 1'b1;
      end
      ArbErr: begin
        in_rsp_o[gnt_q] = '{ready: 1'b1, rdata: 32'h0, error: 1'b1};
        ptr_d           = nxt(gnt_q);
        state_d         = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tidx_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (state_q == ArbBusy && state_d == ArbErr) tidx_q <= gnt_q;
    end
  end

  assign busy_o        = state_q != ArbIdle;
  assign timeout_o     = state_q == ArbErr;
  assign timeout_idx_o = tidx_q;

  // Dropping valid while granted is a requester protocol violation.
  a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ArbBusy) |-> in_req_i[gnt_q].valid);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: randomized and directed checks against a transaction-level arbiter model.
module tb_reg_bus_arbiter;
  import core_v_mcu_pkg::*;

  localparam int N  = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_req_t   in_req [N];
  reg_rsp_t   in_rsp [N];
  reg_req_t   out_req;
  reg_rsp_t   s_rsp;
  logic       busy, tmo;
  logic [0:0] tidx;

  reg_req_t   z_req [N];
  reg_rsp_t   z_in_rsp [N];
  reg_req_t   z_out;
  reg_rsp_t   z_rsp;
  logic       z_busy, z_tmo;
  logic [0:0] z_tidx;

  int n_chk = 0;
  int n_fail = 0;

  reg_bus_arbiter #(.NumReq(N), .TimeoutCycles(TO)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_req_i      (in_req),
    .in_rsp_o      (in_rsp),
    .out_req_o     (out_req),
    .out_rsp_i     (s_rsp),
    .busy_o        (busy),
    .timeout_o     (tmo),
    .timeout_idx_o (tidx)
  );

  reg_bus_arbiter #(.NumReq(N), .TimeoutCycles(0)) u_dut_nto (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_req_i      (z_req),
    .in_rsp_o      (z_in_rsp),
    .out_req_o     (z_out),
    .out_rsp_i     (z_rsp),
    .busy_o        (z_busy),
    .timeout_o     (z_tmo),
    .timeout_idx_o (z_tidx)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: owner of the bus (-1 none), unanswered cycles, round-robin start, pending abort.
  int         own = -1;
  int         wt = 0;
  int         ptr = 0;
  bit         err_m = 1'b0;
  logic [0:0] tidx_m = 1'b0;
  logic [N-1:0] comp = '0;

  always @(negedge clk) begin
    reg_req_t     er;
    reg_rsp_t     ers [N];
    logic         eb, et;
    logic [N-1:0] rt;
    int           p;
    er = '0; eb = 1'b0; et = 1'b0; rt = '0; p = -1;
    for (int i = 0; i < N; i++) ers[i] = '0;
    if (!rst_n) begin
      own = -1; wt = 0; ptr = 0; err_m = 1'b0; tidx_m = 1'b0;
    end else if (err_m) begin
      ers[own] = '{ready: 1'b1, rdata: 32'h0, error: 1'b1};
      eb = 1'b1; et = 1'b1; tidx_m = 1'(own);
      ptr = (own + 1) % N; own = -1; err_m = 1'b0;
    end else if (own >= 0) begin
      er = in_req[own]; ers[own] = s_rsp; rt[own] = 1'b1; eb = 1'b1;
      if (s_rsp.ready) begin
        ptr = (own + 1) % N; own = -1;
      end else begin
        wt++;
        if (wt == TO) err_m = 1'b1;
      end
    end else begin
      for (int k = 0; k < N; k++) if (p < 0 && in_req[(ptr + k) % N].valid) p = (ptr + k) % N;
      if (p >= 0) begin
        er = in_req[p]; ers[p] = s_rsp; rt[p] = 1'b1;
        if (s_rsp.ready) ptr = (p + 1) % N;
        else begin own = p; wt = 0; end
      end
    end
    check("out_req", 128'(out_req), 128'(er));
    check("busy", 128'(busy), 128'(eb));
    check("timeout", 128'(tmo), 128'(et));
    check("timeout_idx", 128'(tidx), 128'(tidx_m));
    for (int i = 0; i < N; i++) begin
      check("rsp_flags", 128'({in_rsp[i].ready, in_rsp[i].error}), 128'({ers[i].ready, ers[i].error}));
      if (ers[i].ready || !rt[i]) check("rsp_rdata", 128'(in_rsp[i].rdata), 128'(ers[i].rdata));
      comp[i] = ers[i].ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (comp[i]) in_req[i].valid = 1'b0;
  endtask

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    in_req[i] = '{valid: 1'b1, addr: a, write: w, wdata: d, wstrb: 4'hF};
  endtask

  task automatic rnd_req(input int i);
    in_req[i] = '{valid: 1'b1, addr: $urandom, write: 1'($urandom), wdata: $urandom, wstrb: 4'($urandom)};
  endtask

  int q[$];
  int nb, nt;
  bit seen;
  int pct [5] = '{5, 40, 100, 5, 40};

  initial begin
    for (int i = 0; i < N; i++) begin
      in_req[i] = '0;
      z_req[i]  = '0;
    end
    s_rsp = '0;
    z_rsp = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters always valid, slave answers on the third cycle of each grant.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) if (!in_req[i].valid) rnd_req(i);
      s_rsp.ready = (c % 3 == 2);
      s_rsp.rdata = $urandom;
      s_rsp.error = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) if (in_rsp[i].ready) q.push_back(i);
      step();
    end
    for (int i = 0; i < N; i++) in_req[i].valid = 1'b0;
    s_rsp = '0;
    check("rr_cnt", 128'(q.size()), 128'(4));
    for (int k = 0; k < 4; k++) check("rr_order", 128'(q[k]), 128'(k % 2));

    // Zero-wait write, then the pointer must have moved to requester 1.
    step();
    issue(0, 1'b1, 32'h1000, 32'hDEADBEEF);
    s_rsp = '{ready: 1'b1, rdata: 32'h0, error: 1'b0};
    @(negedge clk);
    check("zw_addr", 128'(out_req.addr), 128'(32'h1000));
    check("zw_wdata", 128'(out_req.wdata), 128'(32'hDEADBEEF));
    check("zw_ready", 128'(in_rsp[0].ready), 128'(1));
    check("zw_busy", 128'(busy), 128'(0));
    step();
    issue(0, 1'b0, 32'h10, 32'h0);
    issue(1, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    check("zw_ptr", 128'({in_rsp[1].ready, in_rsp[0].ready}), 128'(2'b10));
    step();
    step();
    s_rsp = '0;
    step();

    // Requester 1 read, slave never answers.
    issue(1, 1'b0, 32'h44, 32'h0);
    nb = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (tmo) begin
        seen = 1'b1;
        check("to_busy_cycles", 128'(nb), 128'(8));
        check("to_idx", 128'(tidx), 128'(1));
        check("to_rsp", 128'({in_rsp[1].ready, in_rsp[1].error, in_rsp[1].rdata}), 128'({2'b11, 32'h0}));
        check("to_out_valid", 128'(out_req.valid), 128'(0));
      end else if (busy) nb++;
      step();
    end
    check("to_seen", 128'(seen), 128'(1));
    @(negedge clk);
    check("to_pulse", 128'(tmo), 128'(0));
    check("to_idx_hold", 128'(tidx), 128'(1));
    step();

    // Ready lands on the last cycle before the abort threshold.
    issue(0, 1'b0, 32'h88, 32'h0);
    repeat (8) step();
    s_rsp = '{ready: 1'b1, rdata: 32'hCAFEF00D, error: 1'b0};
    @(negedge clk);
    check("th_rsp", 128'({in_rsp[0].ready, in_rsp[0].error, in_rsp[0].rdata}), 128'({2'b10, 32'hCAFEF00D}));
    check("th_no_timeout", 128'(tmo), 128'(0));
    step();
    s_rsp = '0;
    @(negedge clk);
    check("th_after", 128'({tmo, busy}), 128'(0));

    // Timeout disabled: a 1000-cycle stall still completes normally.
    z_req[0] = '{valid: 1'b1, addr: 32'h20, write: 1'b0, wdata: 32'h0, wstrb: 4'h0};
    @(negedge clk);
    nb = 0; nt = 0;
    repeat (1000) begin
      @(negedge clk);
      nb += int'(z_busy);
      nt += int'(z_tmo);
    end
    @(posedge clk);
    #1 z_rsp = '{ready: 1'b1, rdata: 32'h12345678, error: 1'b0};
    @(negedge clk);
    check("nto_rsp", 128'({z_in_rsp[0].ready, z_in_rsp[0].error, z_in_rsp[0].rdata}), 128'({2'b10, 32'h12345678}));
    check("nto_busy_cycles", 128'(nb), 128'(1000));
    check("nto_timeouts", 128'(nt), 128'(0));
    @(posedge clk);
    #1;
    z_req[0] = '0;
    z_rsp = '0;
    @(negedge clk);
    check("nto_idle", 128'(z_busy), 128'(0));

    // Randomized traffic with varying slave responsiveness.
    foreach (pct[s]) begin
      repeat (300) begin
        step();
        for (int i = 0; i < N; i++) if (!in_req[i].valid && $urandom_range(0, 1) == 1) rnd_req(i);
        s_rsp.ready = ($urandom_range(0, 99) < pct[s]);
        s_rsp.rdata = $urandom;
        s_rsp.error = s_rsp.ready & 1'($urandom);
      end
    end
    repeat (12) begin
      step();
      s_rsp = '{ready: 1'b1, rdata: $urandom, error: 1'b0};
    end
    step();
    s_rsp = '0;
    for (int i = 0; i < N; i++) in_req[i].valid = 1'b0;
    step();

    // Reset in the middle of a stalled transfer.
    issue(0, 1'b1, 32'h200, 32'h55AA55AA);
    issue(1, 1'b0, 32'h204, 32'h0);
    repeat (3) step();
    @(posedge clk);
    #3;
    s_rsp = '{ready: 1'b1, rdata: 32'h0BADF00D, error: 1'b0};
    rst_n = 1'b0;
    #1;
    check("rst_out_req", 128'(out_req), 128'(0));
    check("rst_rsp", 128'({in_rsp[0], in_rsp[1]}), 128'(0));
    check("rst_flags", 128'({busy, tmo, tidx}), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_pick", 128'({in_rsp[1].ready, in_rsp[0].ready}), 128'(2'b01));
    step();
    step();
    s_rsp = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
